psum_acc: RTL

- Partial-sum accumulation stage directly upstream of the ReLU special-function stage.
- Consumes col-lane psum vectors from the array output FIFO over a fixed number of kernel passes.
- Adds each vector into an on-chip accumulator bank, one entry per output position.
- After the final pass, drains the accumulated vectors in order on a valid/ready interface that feeds the ReLU stage.

---
 rtl/psum_acc.sv | 135 +++++++++++++
 1 files changed

// File: rtl/psum_acc.sv
// Partial-sum accumulator: sums col-lane psum vectors over `passes` kernel passes
// into a depth-entry bank, then drains the bank in order to the ReLU stage.
module psum_acc #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int depth   = 16,
    parameter int passes  = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [psum_bw*col-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [psum_bw*col-1:0] out_data,
    output logic                   done,
    output logic [1:0]             o_dbg_state
);

    localparam int vec_w = psum_bw * col;
    localparam int ptr_w = $clog2(depth);
    localparam int cnt_w = (passes > 1) ? $clog2(passes) : 1;

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ptr_w-1:0] ptr_last = ptr_w'(depth - 1);
    localparam logic [ptr_w-1:0] ptr_one  = ptr_w'(1);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(passes - 1);
    localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);

    logic [1:0]       r_state;
    logic [ptr_w-1:0] r_wr_ptr;
    logic [ptr_w-1:0] r_rd_ptr;
    logic [cnt_w-1:0] r_pass_cnt;
    logic [vec_w-1:0] r_acc [depth];

    logic             w_fire;
    logic [vec_w-1:0] w_acc_rd;
    logic [vec_w-1:0] w_sum;
    logic [vec_w-1:0] w_wr_data;

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
    // the sender holds data stable until then. in_ready depends only on state, and clear
    // overrides any transfer on the same edge.
    assign in_ready    = (r_state == ST_ACCUM);
    assign w_fire      = in_valid & in_ready & ~clear;
    assign o_dbg_state = r_state;

    assign w_acc_rd = r_acc[r_wr_ptr];

    genvar g;
    for (g = 0; g < col; g++) begin : g_lane
        logic [psum_bw-1:0] w_a;
        logic [psum_bw-1:0] w_b;
        logic [psum_bw:0]   w_s;
        assign w_a = w_acc_rd[g*psum_bw +: psum_bw];
        assign w_b = in_data[g*psum_bw +: psum_bw];
        assign w_s = {w_a[psum_bw-1], w_a} + {w_b[psum_bw-1], w_b};
        // Extra sign bit disagreeing with the top result bit means signed overflow.
        assign w_sum[g*psum_bw +: psum_bw] =
            (w_s[psum_bw] != w_s[psum_bw-1])
                ? (w_s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}})
                : w_s[psum_bw-1:0];
    end

    assign w_wr_data = (r_pass_cnt == '0) ? in_data : w_sum;

    // Bank has no reset: pass 0 overwrites every entry before it is read.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_acc[r_wr_ptr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_ACCUM;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pass_cnt <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            done       <= 1'b0;
        end else if (clear) begin
            r_state    <= ST_ACCUM;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pass_cnt <= '0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_ACCUM: begin
                    if (w_fire) begin
                        r_wr_ptr <= r_wr_ptr + ptr_one;
                        if (r_wr_ptr == ptr_last) begin
                            if (r_pass_cnt == cnt_last) begin
                                r_pass_cnt <= '0;
                                r_state    <= ST_LOAD;
                            end else begin
                                r_pass_cnt <= r_pass_cnt + cnt_one;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    out_data  <= r_acc[0];
                    out_valid <= 1'b1;
                    r_rd_ptr  <= '0;
                    r_state   <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (r_rd_ptr == ptr_last) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            r_rd_ptr  <= '0;
                            r_state   <= ST_ACCUM;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + ptr_one;
                            out_data <= r_acc[r_rd_ptr + ptr_one];
                        end
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

endmodule
